reg_transfer_engine: RTL and testbench
======================================

Name: reg_transfer_engine

Overview:
- Parametrised successor to the fixed 16x32 register/MDR/bus datapath.
- Executes one bus transfer per accepted command:
  - source: register, MDR loaded from memory, or immediate;
  - destination: any one-hot or multi-hot set of registers.
- Adds a valid/ready command port, a memory read handshake with timeout, an optional hard-wired zero R0, and a debug read port.
- Sits between the control unit and the register file / memory interface.

Parameters:
- DATA_W, 32, width of bus, registers and MDR.
- NUM_REGS, 16, number of general registers (2..64); AW = $clog2(NUM_REGS) is a localparam.
- R0_ZERO, 0, when 1 R0 reads as 0 and ignores writes.
- MEM_TIMEOUT, 15, max cycles waiting for mem_rd_ack (1..255).

Ports:
- clock  in  1  rising-edge clock.
- clear  in  1  asynchronous, active-low reset.
- cmd_valid  in  1  command offered.
- cmd_ready  out  1  engine can accept a command.
- cmd_op  in  2  00 MOVE, 01 LOAD, 10 IMM, 11 READ.
- cmd_src  in  AW  source register index (MOVE/READ).
- cmd_dst_mask  in  NUM_REGS  destination write mask.
- cmd_imm  in  DATA_W  immediate (IMM).
- mem_rd_req  out  1  memory read request.
- mem_rd_ack  in  1  memory data valid.
- mem_rd_data  in  DATA_W  memory read data.
- bus_data  out  DATA_W  current bus value.
- mdr_q  out  DATA_W  MDR contents.
- done  out  1  transfer completes this cycle.
- err  out  1  LOAD timed out this cycle.
- dbg_sel  in  AW  debug read index.
- dbg_data  out  DATA_W  combinational R[dbg_sel], with the R0_ZERO rule applied.

Behaviour:
- Reset (clear=0, asynchronous):
  - state IDLE; all registers, MDR and timeout counter cleared.
  - cmd_ready=1; mem_rd_req, done, err = 0; bus_data = 0.
  - Mid-operation reset aborts the command with no partial write; mem_rd_req drops immediately.
- States: IDLE, MEM_REQ, DRIVE, ERROR. All outputs are decoded from registered state and registered command fields.
- IDLE:
  - cmd_ready=1.
  - On cmd_valid&cmd_ready at edge k, latch op/src/mask/imm.
  - LOAD goes to MEM_REQ with counter=0; all other ops go to DRIVE.
- MEM_REQ:
  - mem_rd_req=1, cmd_ready=0.
  - On mem_rd_ack: MDR <= mem_rd_data, go to DRIVE.
  - Otherwise increment counter; if counter reaches MEM_TIMEOUT-1 without ack, go to ERROR.
  - Ack in the same cycle as the timeout: ack wins.
- DRIVE (exactly one cycle):
  - bus_data source: MOVE/READ R[src], LOAD MDR, IMM cmd_imm.
  - done=1.
  - At the closing edge every register with mask bit set loads bus_data (READ never writes).
  - Next state IDLE.
- ERROR (one cycle): err=1, done=0, no register or MDR write; next state IDLE.
- bus_data = 0 outside DRIVE.
- Latency, accept edge to cmd_ready high again:
  - MOVE/IMM/READ: 2 cycles.
  - LOAD: 2 + wait cycles.
  - Written data is visible on dbg_data in the cycle after done.
- Boundary rules:
  - mask=0 is legal: done still pulses.
  - Multi-bit mask writes all selected registers in the same edge.
  - Src=dst is legal and rewrites the same value.
  - cmd_src >= NUM_REGS reads 0.
  - R0_ZERO=1: R0 reads 0 and mask bit 0 is ignored.
  - mem_rd_ack outside MEM_REQ is ignored.
  - cmd_valid while cmd_ready=0 is ignored; a held command is accepted in the first IDLE cycle.

Decomposition:
- Package rtx_pkg holds:
  - op encodings OP_MOVE/OP_LOAD/OP_IMM/OP_READ;
  - state encodings S_IDLE/S_MEM_REQ/S_DRIVE/S_ERROR.
- Sub-module rtx_regfile: NUM_REGS x DATA_W registers, asynchronous active-low clear, masked multi-write, one read port plus the debug read port, and R0_ZERO handling.

Test Plan:
- Reset state: hold clear=0 for 2 cycles with stray cmd_valid/mem_rd_ack -> cmd_ready=1, bus_data=0, all dbg_data=0, mdr_q=0.
- IMM plus MOVE:
  - IMM 32'h12345678 with mask 16'h0001 -> done in DRIVE cycle, R0=12345678.
  - Then MOVE src=0, mask 16'h0006 -> R1=R2=12345678, bus_data shows the value only in the DRIVE cycle.
- LOAD with 3-cycle ack delay, mem_rd_data 32'h87654321, mask 16'h8000:
  - mem_rd_req high 3 cycles, then mdr_q=87654321, R15=87654321.
  - cmd_ready returns 5 cycles after accept.
- LOAD timeout: MEM_TIMEOUT=15, no ack -> mem_rd_req high 15 cycles, err pulse 1 cycle, done never asserted, registers and MDR unchanged. Repeat with ack on the 15th cycle -> load succeeds.
- R0_ZERO=1 and READ:
  - IMM 32'hFEDCBA98 with mask 16'h0003 -> R0 reads 0, R1=FEDCBA98.
  - READ src=1 -> bus_data=FEDCBA98, no register changes.
- Reset mid-LOAD: drop clear during MEM_REQ -> mem_rd_req falls without a clock edge, all state cleared, a later ack is ignored.

Source files
------------

// File: rtl/rtx_pkg.sv
// Shared encodings for the register transfer engine: command opcodes and FSM states.
package rtx_pkg;

    localparam logic [1:0] OP_MOVE = 2'b00;
    localparam logic [1:0] OP_LOAD = 2'b01;
    localparam logic [1:0] OP_IMM  = 2'b10;
    localparam logic [1:0] OP_READ = 2'b11;

    localparam logic [1:0] S_IDLE    = 2'b00;
    localparam logic [1:0] S_MEM_REQ = 2'b01;
    localparam logic [1:0] S_DRIVE   = 2'b10;
    localparam logic [1:0] S_ERROR   = 2'b11;

endpackage

// File: rtl/rtx_regfile.sv
// NUM_REGS x DATA_W register file: masked multi-write, one read port plus a debug port.
// Writes land at the clock edge; reads are combinational. There is no backpressure.
module rtx_regfile #(
    parameter int DATA_W   = 32,
    parameter int NUM_REGS = 16,
    parameter int R0_ZERO  = 0,
    parameter int AW       = $clog2(NUM_REGS)
) (
    input  logic                clk_i,
    input  logic                rst_n_i,
    input  logic [NUM_REGS-1:0] we_mask_i,
    input  logic [DATA_W-1:0]   wr_dat_i,
    input  logic [AW-1:0]       rd_idx_i,
    output logic [DATA_W-1:0]   rd_dat_o,
    input  logic [AW-1:0]       dbg_idx_i,
    output logic [DATA_W-1:0]   dbg_dat_o
);

    logic [DATA_W-1:0] regs_q [NUM_REGS];
    logic              rd_ok;
    logic              dbg_ok;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_REGS; i++) begin
                // A hard-wired zero R0 never takes a write, so it stays at its reset value.
                if (we_mask_i[i] && !(R0_ZERO != 0 && i == 0)) begin
                    regs_q[i] <= wr_dat_i;
                end
            end
        end
    end

    assign rd_ok  = (int'(rd_idx_i) < NUM_REGS) && !(R0_ZERO != 0 && rd_idx_i == '0);
    assign dbg_ok = (int'(dbg_idx_i) < NUM_REGS) && !(R0_ZERO != 0 && dbg_idx_i == '0);

    assign rd_dat_o  = rd_ok  ? regs_q[rd_idx_i]  : '0;
    assign dbg_dat_o = dbg_ok ? regs_q[dbg_idx_i] : '0;

endmodule

// File: rtl/reg_transfer_engine.sv
// One bus transfer per accepted command (reg/MDR/immediate -> masked register set).
// Latency 2 cycles, LOAD 2 + memory wait; cmd_ready is low from accept until back in IDLE.
module reg_transfer_engine
    import rtx_pkg::*;
#(
    parameter int DATA_W      = 32,
    parameter int NUM_REGS    = 16,
    parameter int R0_ZERO     = 0,
    parameter int MEM_TIMEOUT = 15
) (
    input  logic                        clock,
    input  logic                        clear,
    input  logic                        cmd_valid,
    output logic                        cmd_ready,
    input  logic [1:0]                  cmd_op,
    input  logic [$clog2(NUM_REGS)-1:0] cmd_src,
    input  logic [NUM_REGS-1:0]         cmd_dst_mask,
    input  logic [DATA_W-1:0]           cmd_imm,
    output logic                        mem_rd_req,
    input  logic                        mem_rd_ack,
    input  logic [DATA_W-1:0]           mem_rd_data,
    output logic [DATA_W-1:0]           bus_data,
    output logic [DATA_W-1:0]           mdr_q,
    output logic                        done,
    output logic                        err,
    input  logic [$clog2(NUM_REGS)-1:0] dbg_sel,
    output logic [DATA_W-1:0]           dbg_data
);

    localparam int AW = $clog2(NUM_REGS);

    logic [1:0]          state_q, state_d;
    logic [1:0]          op_q, op_d;
    logic [AW-1:0]       src_q, src_d;
    logic [NUM_REGS-1:0] mask_q, mask_d;
    logic [DATA_W-1:0]   imm_q, imm_d;
    logic [DATA_W-1:0]   mdr_d;
    logic [7:0]          cnt_q, cnt_d;

    logic [NUM_REGS-1:0] we_mask;
    logic [DATA_W-1:0]   rd_dat;

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        src_d   = src_q;
        mask_d  = mask_q;
        imm_d   = imm_q;
        mdr_d   = mdr_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (cmd_valid) begin
                    op_d    = cmd_op;
                    src_d   = cmd_src;
                    mask_d  = cmd_dst_mask;
                    imm_d   = cmd_imm;
                    cnt_d   = '0;
                    state_d = (cmd_op == OP_LOAD) ? S_MEM_REQ : S_DRIVE;
                end
            end
            S_MEM_REQ: begin
                // An ack arriving on the final allowed cycle still beats the timeout.
                if (mem_rd_ack) begin
                    mdr_d   = mem_rd_data;
                    state_d = S_DRIVE;
                end else if (cnt_q == 8'(MEM_TIMEOUT - 1)) begin
                    state_d = S_ERROR;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            S_DRIVE:  state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            state_q <= S_IDLE;
            op_q    <= '0;
            src_q   <= '0;
            mask_q  <= '0;
            imm_q   <= '0;
            mdr_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            src_q   <= src_d;
            mask_q  <= mask_d;
            imm_q   <= imm_d;
            mdr_q   <= mdr_d;
            cnt_q   <= cnt_d;
        end
    end

    assign cmd_ready  = (state_q == S_IDLE);
    assign mem_rd_req = (state_q == S_MEM_REQ);
    assign done       = (state_q == S_DRIVE);
    assign err        = (state_q == S_ERROR);

    always_comb begin
        bus_data = '0;
        if (state_q == S_DRIVE) begin
            case (op_q)
                OP_LOAD: bus_data = mdr_q;
                OP_IMM:  bus_data = imm_q;
                default: bus_data = rd_dat;
            endcase
        end
    end

    assign we_mask = (state_q == S_DRIVE && op_q != OP_READ) ? mask_q : '0;

    rtx_regfile #(
        .DATA_W   (DATA_W),
        .NUM_REGS (NUM_REGS),
        .R0_ZERO  (R0_ZERO),
        .AW       (AW)
    ) u_regfile (
        .clk_i     (clock),
        .rst_n_i   (clear),
        .we_mask_i (we_mask),
        .wr_dat_i  (bus_data),
        .rd_idx_i  (src_q),
        .rd_dat_o  (rd_dat),
        .dbg_idx_i (dbg_sel),
        .dbg_dat_o (dbg_data)
    );

endmodule

// File: tb/tb_reg_transfer_engine.sv
// Directed bench: instance a has a normal R0, instance b has a hard-wired zero R0.
module tb_reg_transfer_engine;

    logic        clock = 1'b0;
    always #5 clock = ~clock;

    int tests = 0;
    int fails = 0;

    logic        a_clear, a_cmd_valid, a_cmd_ready, a_req, a_ack, a_done, a_err;
    logic [1:0]  a_op;
    logic [3:0]  a_src, a_dbg_sel;
    logic [15:0] a_mask;
    logic [31:0] a_imm, a_rdata, a_bus, a_mdr, a_dbg;

    logic        b_clear, b_cmd_valid, b_cmd_ready, b_req, b_ack, b_done, b_err;
    logic [1:0]  b_op;
    logic [3:0]  b_src, b_dbg_sel;
    logic [15:0] b_mask;
    logic [31:0] b_imm, b_rdata, b_bus, b_mdr, b_dbg;

    reg_transfer_engine #(.DATA_W(32), .NUM_REGS(16), .R0_ZERO(0), .MEM_TIMEOUT(15)) u_dut_a (
        .clock(clock), .clear(a_clear), .cmd_valid(a_cmd_valid), .cmd_ready(a_cmd_ready),
        .cmd_op(a_op), .cmd_src(a_src), .cmd_dst_mask(a_mask), .cmd_imm(a_imm),
        .mem_rd_req(a_req), .mem_rd_ack(a_ack), .mem_rd_data(a_rdata),
        .bus_data(a_bus), .mdr_q(a_mdr), .done(a_done), .err(a_err),
        .dbg_sel(a_dbg_sel), .dbg_data(a_dbg)
    );

    reg_transfer_engine #(.DATA_W(32), .NUM_REGS(16), .R0_ZERO(1), .MEM_TIMEOUT(15)) u_dut_b (
        .clock(clock), .clear(b_clear), .cmd_valid(b_cmd_valid), .cmd_ready(b_cmd_ready),
        .cmd_op(b_op), .cmd_src(b_src), .cmd_dst_mask(b_mask), .cmd_imm(b_imm),
        .mem_rd_req(b_req), .mem_rd_ack(b_ack), .mem_rd_data(b_rdata),
        .bus_data(b_bus), .mdr_q(b_mdr), .done(b_done), .err(b_err),
        .dbg_sel(b_dbg_sel), .dbg_data(b_dbg)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    initial begin
        a_clear = 1'b0; a_cmd_valid = 1'b1; a_op = 2'b10; a_src = '0; a_mask = 16'hFFFF;
        a_imm = 32'hA5A5A5A5; a_ack = 1'b1; a_rdata = 32'hDEADBEEF; a_dbg_sel = '0;
        b_clear = 1'b0; b_cmd_valid = 1'b0; b_op = '0; b_src = '0; b_mask = '0;
        b_imm = '0; b_ack = 1'b0; b_rdata = '0; b_dbg_sel = '0;

        // Reset held for two edges with stray valid and ack.
        tick();
        tick();
        chk("rst_ready", 32'(a_cmd_ready), 32'd1);
        chk("rst_bus", a_bus, 32'h0);
        chk("rst_mdr", a_mdr, 32'h0);
        chk("rst_req", 32'(a_req), 32'd0);
        chk("rst_done", 32'(a_done), 32'd0);
        chk("rst_err", 32'(a_err), 32'd0);
        for (int i = 0; i < 16; i++) begin
            a_dbg_sel = 4'(i);
            #1;
            chk($sformatf("rst_dbg%0d", i), a_dbg, 32'h0);
        end
        a_cmd_valid = 1'b0;
        a_clear = 1'b1;
        b_clear = 1'b1;
        tick();

        // IMM into R0, with a stray ack that must not touch MDR.
        a_cmd_valid = 1'b1; a_op = 2'b10; a_imm = 32'h12345678; a_mask = 16'h0001;
        a_ack = 1'b1; a_rdata = 32'hDEADBEEF;
        tick();
        a_cmd_valid = 1'b0;
        chk("imm_done", 32'(a_done), 32'd1);
        chk("imm_bus", a_bus, 32'h12345678);
        chk("imm_ready", 32'(a_cmd_ready), 32'd0);
        tick();
        a_ack = 1'b0;
        chk("imm_done_off", 32'(a_done), 32'd0);
        chk("imm_bus_off", a_bus, 32'h0);
        chk("imm_ready_back", 32'(a_cmd_ready), 32'd1);
        chk("stray_ack_mdr", a_mdr, 32'h0);
        a_dbg_sel = 4'd0; #1;
        chk("imm_r0", a_dbg, 32'h12345678);

        // MOVE R0 -> R1,R2.
        a_cmd_valid = 1'b1; a_op = 2'b00; a_src = 4'd0; a_mask = 16'h0006;
        tick();
        a_cmd_valid = 1'b0;
        chk("move_bus", a_bus, 32'h12345678);
        chk("move_done", 32'(a_done), 32'd1);
        tick();
        chk("move_bus_off", a_bus, 32'h0);
        a_dbg_sel = 4'd1; #1;
        chk("move_r1", a_dbg, 32'h12345678);
        a_dbg_sel = 4'd2; #1;
        chk("move_r2", a_dbg, 32'h12345678);
        a_dbg_sel = 4'd3; #1;
        chk("move_r3", a_dbg, 32'h0);

        // LOAD with ack in the third request cycle.
        a_cmd_valid = 1'b1; a_op = 2'b01; a_mask = 16'h8000; a_rdata = 32'h87654321;
        tick();
        a_cmd_valid = 1'b0;
        chk("ld_req1", 32'(a_req), 32'd1);
        chk("ld_ready1", 32'(a_cmd_ready), 32'd0);
        tick();
        chk("ld_req2", 32'(a_req), 32'd1);
        tick();
        chk("ld_req3", 32'(a_req), 32'd1);
        a_ack = 1'b1;
        tick();
        a_ack = 1'b0;
        chk("ld_req_off", 32'(a_req), 32'd0);
        chk("ld_done", 32'(a_done), 32'd1);
        chk("ld_mdr", a_mdr, 32'h87654321);
        chk("ld_bus", a_bus, 32'h87654321);
        chk("ld_ready_drive", 32'(a_cmd_ready), 32'd0);
        tick();
        chk("ld_ready_back", 32'(a_cmd_ready), 32'd1);
        a_dbg_sel = 4'd15; #1;
        chk("ld_r15", a_dbg, 32'h87654321);

        // LOAD timeout: 15 request cycles, one err cycle, nothing written.
        a_cmd_valid = 1'b1; a_op = 2'b01; a_mask = 16'h0001; a_rdata = 32'h55555555;
        tick();
        a_cmd_valid = 1'b0;
        for (int i = 0; i < 15; i++) begin
            chk($sformatf("to_req%0d", i), 32'(a_req), 32'd1);
            chk($sformatf("to_done%0d", i), 32'(a_done), 32'd0);
            tick();
        end
        chk("to_err", 32'(a_err), 32'd1);
        chk("to_req_off", 32'(a_req), 32'd0);
        chk("to_err_done", 32'(a_done), 32'd0);
        tick();
        chk("to_err_off", 32'(a_err), 32'd0);
        chk("to_ready", 32'(a_cmd_ready), 32'd1);
        chk("to_mdr_kept", a_mdr, 32'h87654321);
        a_dbg_sel = 4'd0; #1;
        chk("to_r0_kept", a_dbg, 32'h12345678);

        // Same LOAD, ack on the 15th cycle wins over the timeout.
        a_cmd_valid = 1'b1;
        tick();
        a_cmd_valid = 1'b0;
        for (int i = 0; i < 14; i++) tick();
        chk("late_req15", 32'(a_req), 32'd1);
        a_ack = 1'b1;
        tick();
        a_ack = 1'b0;
        chk("late_done", 32'(a_done), 32'd1);
        chk("late_err", 32'(a_err), 32'd0);
        chk("late_mdr", a_mdr, 32'h55555555);
        tick();
        a_dbg_sel = 4'd0; #1;
        chk("late_r0", a_dbg, 32'h55555555);

        // Reset in the middle of a LOAD.
        a_cmd_valid = 1'b1; a_mask = 16'h0002; a_rdata = 32'h99999999;
        tick();
        a_cmd_valid = 1'b0;
        chk("mid_req", 32'(a_req), 32'd1);
        tick();
        #2 a_clear = 1'b0;
        #1;
        chk("mid_req_drop", 32'(a_req), 32'd0);
        chk("mid_ready", 32'(a_cmd_ready), 32'd1);
        chk("mid_mdr", a_mdr, 32'h0);
        a_ack = 1'b1;
        tick();
        a_clear = 1'b1;
        tick();
        tick();
        a_ack = 1'b0;
        chk("mid_ack_mdr", a_mdr, 32'h0);
        chk("mid_ack_req", 32'(a_req), 32'd0);
        chk("mid_ack_done", 32'(a_done), 32'd0);
        a_dbg_sel = 4'd1; #1;
        chk("mid_r1", a_dbg, 32'h0);

        // Hard-wired zero R0: IMM to R0,R1 then READ R1.
        b_cmd_valid = 1'b1; b_op = 2'b10; b_imm = 32'hFEDCBA98; b_mask = 16'h0003;
        tick();
        b_cmd_valid = 1'b0;
        chk("z_imm_done", 32'(b_done), 32'd1);
        chk("z_imm_bus", b_bus, 32'hFEDCBA98);
        tick();
        b_dbg_sel = 4'd0; #1;
        chk("z_r0", b_dbg, 32'h0);
        b_dbg_sel = 4'd1; #1;
        chk("z_r1", b_dbg, 32'hFEDCBA98);
        b_cmd_valid = 1'b1; b_op = 2'b11; b_src = 4'd1; b_mask = 16'h000C;
        tick();
        b_cmd_valid = 1'b0;
        chk("z_read_bus", b_bus, 32'hFEDCBA98);
        chk("z_read_done", 32'(b_done), 32'd1);
        tick();
        b_dbg_sel = 4'd2; #1;
        chk("z_read_r2", b_dbg, 32'h0);
        b_dbg_sel = 4'd3; #1;
        chk("z_read_r3", b_dbg, 32'h0);
        b_dbg_sel = 4'd1; #1;
        chk("z_read_r1", b_dbg, 32'hFEDCBA98);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
